// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: opcode constants and FSM states.
package alu_share_ctrl_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_SLL  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request, response and ALU-side signals of the ALU sharing controller.
interface alu_share_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDW   = 1
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_of;
    logic                  rsp_zf;
    logic [WIDTH-1:0]      alu_dina;
    logic [WIDTH-1:0]      alu_dinb;
    logic [2:0]            alu_opa;
    logic [WIDTH-1:0]      alu_douta;
    logic                  alu_ofa;
    logic                  alu_zfa;
    logic                  busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
               alu_douta, alu_ofa, alu_zfa,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_of, rsp_zf,
               alu_dina, alu_dinb, alu_opa, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
               alu_douta, alu_ofa, alu_zfa,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_of, rsp_zf,
               alu_dina, alu_dinb, alu_opa, busy
    );
endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin search from ptr: one-hot grant, its index, and an any-request flag.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    localparam int unsigned SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    int unsigned j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (!any && req[SW'(j)]) begin
                grant[SW'(j)] = 1'b1;
                idx           = IDW'(j);
                any           = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU among NREQ requesters with round-robin arbitration
// and registered operands/results around the ALU.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDW   = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_share_ctrl_if.slave  bus
);
    state_e           state;
    state_e           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   g_idx;
    logic             any;
    logic             hs;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] data_q;
    logic             of_q;
    logic             zf_q;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (g_idx),
        .any   (any)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state plus the combinational accept, which is offered only while idle
    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        hs            = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = grant;
                hs            = any;
                if (any) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            data_q <= '0;
            of_q   <= 1'b0;
            zf_q   <= 1'b0;
        end else begin
            if (hs) begin
                op_q   <= bus.req_op[32'(g_idx)*3 +: 3];
                a_q    <= bus.req_a[32'(g_idx)*WIDTH +: WIDTH];
                b_q    <= bus.req_b[32'(g_idx)*WIDTH +: WIDTH];
                id_q   <= g_idx;
                rr_ptr <= (g_idx == IDW'(NREQ-1)) ? '0 : g_idx + IDW'(1);
            end
            // ALU ofa is only meaningful for add/sub; anything else is a stale value
            if (state == ST_EXEC) begin
                data_q <= bus.alu_douta;
                zf_q   <= bus.alu_zfa;
                of_q   <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? bus.alu_ofa : 1'b0;
            end
        end
    end

    assign bus.alu_dina  = a_q;
    assign bus.alu_dinb  = b_q;
    assign bus.alu_opa   = op_q;
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_of    = of_q;
    assign bus.rsp_zf    = zf_q;
    assign bus.busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: a 2-requester and a 4-requester instance, each with a behavioural ALU.
module tb_alu_share_ctrl;
    import alu_share_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.WIDTH(32), .NREQ(2), .IDW(1)) b0 ();
    alu_share_ctrl_if #(.WIDTH(32), .NREQ(4), .IDW(2)) b1 ();

    alu_share_ctrl #(.WIDTH(32), .NREQ(2), .IDW(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
    alu_share_ctrl #(.WIDTH(32), .NREQ(4), .IDW(2)) u1 (.clk(clk), .rst(rst), .bus(b1));

    // Behavioural ALU; ofa outside add/sub is deliberately left high, like a stale carry
    function automatic logic [33:0] alu_f(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        logic [32:0] s;
        logic [31:0] d;
        logic        of;
        s  = '0;
        of = 1'b1;
        case (op)
            OP_AND:  d = a & b;
            OP_OR:   d = a | b;
            OP_XOR:  d = a ^ b;
            OP_NOR:  d = ~(a | b);
            OP_ADD:  begin s = {1'b0, a} + {1'b0, b}; d = s[31:0]; of = s[32]; end
            OP_SUB:  begin s = {1'b0, a} - {1'b0, b}; d = s[31:0]; of = s[32]; end
            OP_SLTU: d = 32'(a < b);
            default: d = b << a[4:0];
        endcase
        return {of, (d == 32'd0), d};
    endfunction

    always_comb {b0.alu_ofa, b0.alu_zfa, b0.alu_douta} = alu_f(b0.alu_opa, b0.alu_dina, b0.alu_dinb);
    always_comb {b1.alu_ofa, b1.alu_zfa, b1.alu_douta} = alu_f(b1.alu_opa, b1.alu_dina, b1.alu_dinb);

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv0(input int i, input logic v, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        b0.req_valid[i]      = v;
        b0.req_op[i*3 +: 3]  = op;
        b0.req_a[i*32 +: 32] = a;
        b0.req_b[i*32 +: 32] = b;
    endtask

    task automatic drv1(input int i, input logic v, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        b1.req_valid[i]      = v;
        b1.req_op[i*3 +: 3]  = op;
        b1.req_a[i*32 +: 32] = a;
        b1.req_b[i*32 +: 32] = b;
    endtask

    logic [31:0] t2_data [2];

    initial begin
        rst          = 1'b1;
        b0.req_valid = '0; b0.req_op = '0; b0.req_a = '0; b0.req_b = '0; b0.rsp_ready = 1'b0;
        b1.req_valid = '0; b1.req_op = '0; b1.req_a = '0; b1.req_b = '0; b1.rsp_ready = 1'b1;
        t2_data[0] = 32'd3;
        t2_data[1] = 32'hFF;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_rsp_valid", 64'(b0.rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(b0.req_ready), 64'd0);
        chk("rst_busy",      64'(b0.busy),      64'd0);
        chk("rst_rsp_data",  64'(b0.rsp_data),  64'd0);
        chk("rst_alu_dina",  64'(b0.alu_dina),  64'd0);
        rst          = 1'b0;
        b0.rsp_ready = 1'b1;

        // 1: single ADD with carry-out and zero result
        @(negedge clk);
        drv0(0, 1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1);
        #1 chk("t1_grant", 64'(b0.req_ready), 64'b01);
        @(negedge clk);
        drv0(0, 1'b0, OP_AND, 32'd0, 32'd0);
        chk("t1_exec_busy",  64'(b0.busy),      64'd1);
        chk("t1_exec_valid", 64'(b0.rsp_valid), 64'd0);
        chk("t1_alu_dina",   64'(b0.alu_dina),  64'hFFFF_FFFF);
        chk("t1_alu_opa",    64'(b0.alu_opa),   64'(OP_ADD));
        @(negedge clk);
        chk("t1_rsp_valid", 64'(b0.rsp_valid), 64'd1);
        chk("t1_rsp_data",  64'(b0.rsp_data),  64'd0);
        chk("t1_rsp_zf",    64'(b0.rsp_zf),    64'd1);
        chk("t1_rsp_of",    64'(b0.rsp_of),    64'd1);
        chk("t1_rsp_id",    64'(b0.rsp_id),    64'd0);
        @(negedge clk);
        chk("t1_idle_busy", 64'(b0.busy), 64'd0);

        // 2: both requesters held valid -> alternating grants, 3 cycles per op
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drv0(0, 1'b1, OP_ADD, 32'd1, 32'd2);
        drv0(1, 1'b1, OP_XOR, 32'hF0, 32'h0F);
        for (int k = 0; k < 4; k++) begin
            #1 chk("t2_grant", 64'(b0.req_ready), 64'(2'b01 << (k % 2)));
            @(negedge clk);
            chk("t2_exec_ready", 64'(b0.req_ready), 64'd0);
            @(negedge clk);
            chk("t2_rsp_valid", 64'(b0.rsp_valid), 64'd1);
            chk("t2_rsp_id",    64'(b0.rsp_id),    64'(k % 2));
            chk("t2_rsp_data",  64'(b0.rsp_data),  64'(t2_data[k % 2]));
            @(negedge clk);
        end
        drv0(0, 1'b0, OP_AND, 32'd0, 32'd0);
        drv0(1, 1'b0, OP_AND, 32'd0, 32'd0);

        // 3: SUB with borrow, response back-pressured for 4 cycles
        b0.rsp_ready = 1'b0;
        drv0(1, 1'b1, OP_SUB, 32'd5, 32'd7);
        #1 chk("t3_grant", 64'(b0.req_ready), 64'b10);
        @(negedge clk);
        drv0(1, 1'b0, OP_AND, 32'd0, 32'd0);
        drv0(0, 1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd2);
        chk("t3_exec_ready", 64'(b0.req_ready), 64'd0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("t3_hold_valid", 64'(b0.rsp_valid), 64'd1);
            chk("t3_hold_data",  64'(b0.rsp_data),  64'hFFFF_FFFE);
            chk("t3_hold_of",    64'(b0.rsp_of),    64'd1);
            chk("t3_hold_id",    64'(b0.rsp_id),    64'd1);
            chk("t3_hold_ready", 64'(b0.req_ready), 64'd0);
            @(negedge clk);
        end
        b0.rsp_ready = 1'b1;
        #1 chk("t3_resp_ready", 64'(b0.req_ready), 64'd0);
        @(negedge clk);
        chk("t3_next_grant", 64'(b0.req_ready), 64'b01);

        // 4: ADD with carry, then SLTU whose stale ofa must be masked
        @(negedge clk);
        drv0(0, 1'b0, OP_AND, 32'd0, 32'd0);
        drv0(1, 1'b1, OP_SLTU, 32'd3, 32'd9);
        @(negedge clk);
        chk("t4_add_data", 64'(b0.rsp_data), 64'd1);
        chk("t4_add_of",   64'(b0.rsp_of),   64'd1);
        chk("t4_add_zf",   64'(b0.rsp_zf),   64'd0);
        @(negedge clk);
        chk("t4_grant", 64'(b0.req_ready), 64'b10);
        @(negedge clk);
        drv0(1, 1'b0, OP_AND, 32'd0, 32'd0);
        @(negedge clk);
        chk("t4_sltu_data", 64'(b0.rsp_data), 64'd1);
        chk("t4_sltu_of",   64'(b0.rsp_of),   64'd0);
        chk("t4_sltu_zf",   64'(b0.rsp_zf),   64'd0);
        chk("t4_sltu_id",   64'(b0.rsp_id),   64'd1);
        @(negedge clk);

        // 5: reset during EXEC drops the op and returns rr_ptr to 0
        drv0(0, 1'b1, OP_ADD, 32'd1, 32'd1);
        #1 chk("t5_grant", 64'(b0.req_ready), 64'b01);
        @(negedge clk);
        drv0(0, 1'b0, OP_AND, 32'd0, 32'd0);
        chk("t5_exec_busy", 64'(b0.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy",     64'(b0.busy),      64'd0);
        chk("t5_valid",    64'(b0.rsp_valid), 64'd0);
        chk("t5_rsp_data", 64'(b0.rsp_data),  64'd0);
        chk("t5_alu_dina", 64'(b0.alu_dina),  64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_no_rsp", 64'(b0.rsp_valid), 64'd0);
        end
        drv0(0, 1'b1, OP_AND, 32'd1, 32'd1);
        drv0(1, 1'b1, OP_OR,  32'd1, 32'd1);
        #1 chk("t5_ptr_zero", 64'(b0.req_ready), 64'b01);
        drv0(0, 1'b0, OP_AND, 32'd0, 32'd0);
        drv0(1, 1'b0, OP_AND, 32'd0, 32'd0);

        // 6: NREQ=4, ptr=1, only r3 valid -> grant 3, SLL, ptr wraps to 0
        @(negedge clk);
        drv1(0, 1'b1, OP_AND, 32'hF, 32'h3);
        #1 chk("t6_setup_grant", 64'(b1.req_ready), 64'b0001);
        @(negedge clk);
        drv1(0, 1'b0, OP_AND, 32'd0, 32'd0);
        @(negedge clk);
        chk("t6_setup_data", 64'(b1.rsp_data), 64'd3);
        @(negedge clk);
        drv1(3, 1'b1, OP_SLL, 32'd4, 32'd1);
        #1 chk("t6_grant", 64'(b1.req_ready), 64'b1000);
        @(negedge clk);
        drv1(3, 1'b0, OP_AND, 32'd0, 32'd0);
        chk("t6_alu_opa", 64'(b1.alu_opa), 64'(OP_SLL));
        @(negedge clk);
        chk("t6_rsp_id",   64'(b1.rsp_id),   64'd3);
        chk("t6_rsp_data", 64'(b1.rsp_data), 64'd16);
        chk("t6_rsp_of",   64'(b1.rsp_of),   64'd0);
        chk("t6_rsp_zf",   64'(b1.rsp_zf),   64'd0);
        @(negedge clk);
        drv1(1, 1'b1, OP_AND, 32'd0, 32'd0);
        drv1(3, 1'b1, OP_AND, 32'd0, 32'd0);
        #1 chk("t6_wrap_grant", 64'(b1.req_ready), 64'b0010);
        drv1(1, 1'b0, OP_AND, 32'd0, 32'd0);
        drv1(3, 1'b0, OP_AND, 32'd0, 32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
